mem_bus_arbiter: RTL and testbench

- Shares the single downstream SRAM-like memory port of the CPU core between two requesters: instruction fetch (IF, read-only) and the MEM stage (read/write).
- Sequences one outstanding transaction at a time.
- Returns read data and completion pulses to the owning requester.
- Drives per-stage stall requests into the pipeline control unit, which produces the stall vector and flush for the IF/ID … MEM/WB registers.
- Discards the instruction-fetch response when the pipeline is flushed.

---
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares the core's single SRAM-like memory port between instruction fetch and the MEM stage.
// Handles one transaction at a time, returns data/complete pulses, and drops fetch responses killed by flush.
module mem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              stallreq_if,
   output logic              stallreq_mem,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;   // 0 = inst, 1 = data
   logic                kill_q, kill_d;
   logic                wr_q, wr_d;
   logic [1:0]          size_q, size_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                inst_ok_q, inst_ok_d;
   logic                data_ok_q, data_ok_d;
   logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
   logic                enter_resp;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      kill_d       = kill_q;
      wr_d         = wr_q;
      size_d       = size_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      inst_ok_d    = 1'b0;
      data_ok_d    = 1'b0;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      enter_resp   = 1'b0;

      case (state_q)
         IDLE: begin
            if (data_req) begin
               owner_d = 1'b1;
               kill_d  = 1'b0;
               wr_d    = data_wr;
               size_d  = data_size;
               addr_d  = data_addr;
               wdata_d = data_wdata;
               state_d = ADDR;
            end else if (inst_req && !flush) begin
               owner_d = 1'b0;
               kill_d  = 1'b0;
               wr_d    = 1'b0;
               size_d  = 2'd2;
               addr_d  = inst_addr;
               wdata_d = '0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (bus_addr_ok) begin
               if (bus_data_ok) enter_resp = 1'b1;
               else             state_d    = DATA;
            end
         end
         DATA: begin
            if (bus_data_ok) enter_resp = 1'b1;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && !owner_q && flush) kill_d = 1'b1;

      // The pulse is registered, so it is decided on entry to RESP and lands during the RESP cycle;
      // a flush in that entry cycle counts the same as an earlier one.
      if (enter_resp) begin
         state_d = RESP;
         if (owner_q) begin
            data_ok_d    = 1'b1;
            data_rdata_d = bus_rdata;
         end else if (!(kill_q || flush)) begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = bus_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         kill_q       <= 1'b0;
         wr_q         <= 1'b0;
         size_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         inst_ok_q    <= 1'b0;
         data_ok_q    <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         kill_q       <= kill_d;
         wr_q         <= wr_d;
         size_q       <= size_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         inst_ok_q    <= inst_ok_d;
         data_ok_q    <= data_ok_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign inst_data_ok = inst_ok_q;
   assign inst_rdata   = inst_rdata_q;
   assign data_data_ok = data_ok_q;
   assign data_rdata   = data_rdata_q;
   assign stallreq_if  = inst_req & ~inst_ok_q;
   assign stallreq_mem = data_req & ~data_ok_q;
   assign bus_req      = (state_q == ADDR);
   assign bus_wr       = wr_q;
   assign bus_size     = size_q;
   assign bus_addr     = addr_q;
   assign bus_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a bus responder checks issued transactions,
// a monitor checks every data_ok pulse against the expected-response queues.
module tb_mem_bus_arbiter;

   logic        clk, rst, flush;
   logic        inst_req, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        stallreq_if, stallreq_mem;
   logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] wdata;
   } bus_txn_t;

   bus_txn_t    exp_bus_q[$];
   logic [31:0] exp_inst_q[$];
   logic [31:0] exp_data_q[$];

   int compared = 0;
   int errors   = 0;
   int cyc      = 0;
   int addr_lat = 0;
   int data_lat = 0;
   int acc_cnt  = 0;
   int bdok_cyc = 0;
   int iok_cyc  = 0;
   int dok_cyc  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rsp_model(input logic [31:0] a);
      if (a == 32'hBFC0_0000) return 32'h3C08_0001;
      return a ^ 32'hA5A5_5A5A;
   endfunction

   // Memory responder: waits addr_lat cycles to accept, answers data_lat cycles after accept.
   initial begin : responder
      bit          pend;
      int          acnt, dcnt;
      logic [31:0] pend_data;
      bus_txn_t    e;
      pend = 0; dcnt = 0; pend_data = '0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      acnt = addr_lat;
      forever begin
         @(negedge clk);
         bus_addr_ok = 1'b0;
         bus_data_ok = 1'b0;
         if (pend) begin
            if (dcnt == 0) begin
               bus_data_ok = 1'b1; bus_rdata = pend_data; pend = 0; bdok_cyc = cyc;
            end else dcnt--;
         end else if (bus_req === 1'b1) begin
            if (acnt <= 0) begin
               bus_addr_ok = 1'b1; acc_cnt++; acnt = addr_lat;
               compared++;
               if (exp_bus_q.size() == 0) begin
                  errors++;
                  $display("FAIL bus_unexpected: got addr=%h wr=%b, required no transaction", bus_addr, bus_wr);
               end else begin
                  e = exp_bus_q.pop_front();
                  if (bus_addr !== e.addr || bus_wr !== e.wr || bus_size !== e.size ||
                      (e.wr && bus_wdata !== e.wdata)) begin
                     errors++;
                     $display("FAIL bus_txn: got addr=%h wr=%b size=%0d wdata=%h, required addr=%h wr=%b size=%0d wdata=%h",
                              bus_addr, bus_wr, bus_size, bus_wdata, e.addr, e.wr, e.size, e.wdata);
                  end
               end
               pend_data = rsp_model(bus_addr);
               if (data_lat == 0) begin
                  bus_data_ok = 1'b1; bus_rdata = pend_data; bdok_cyc = cyc;
               end else begin
                  pend = 1; dcnt = data_lat - 1;
               end
            end else acnt--;
         end else acnt = addr_lat;
      end
   end

   // Response monitor: every pulse must match the head of its expected queue.
   always @(negedge clk) begin
      if (inst_data_ok === 1'b1) begin
         iok_cyc = cyc;
         compared++;
         if (exp_inst_q.size() == 0) begin
            errors++;
            $display("FAIL inst_ok_unexpected: got pulse rdata=%h, required no pulse", inst_rdata);
         end else begin
            logic [31:0] x;
            x = exp_inst_q.pop_front();
            if (inst_rdata !== x) begin
               errors++;
               $display("FAIL inst_rdata: got %h, required %h", inst_rdata, x);
            end
         end
      end
      if (data_data_ok === 1'b1) begin
         dok_cyc = cyc;
         compared++;
         if (exp_data_q.size() == 0) begin
            errors++;
            $display("FAIL data_ok_unexpected: got pulse rdata=%h, required no pulse", data_rdata);
         end else begin
            logic [31:0] y;
            y = exp_data_q.pop_front();
            if (data_rdata !== y) begin
               errors++;
               $display("FAIL data_rdata: got %h, required %h", data_rdata, y);
            end
         end
      end
   end

   task automatic push_bus(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] d);
      bus_txn_t t;
      t.addr = a; t.wr = w; t.size = s; t.wdata = d;
      exp_bus_q.push_back(t);
   endtask

   task automatic run_fetch(input logic [31:0] a);
      bit got;
      got = 0;
      @(negedge clk);
      inst_req = 1'b1; inst_addr = a;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (inst_data_ok === 1'b1) begin got = 1; break; end
      end
      if (!got) begin
         compared++; errors++;
         $display("FAIL fetch_timeout: got no inst_data_ok for %h, required a pulse", a);
      end
      @(negedge clk);
      inst_req = 1'b0;
   endtask

   task automatic run_data(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      bit got;
      got = 0;
      @(negedge clk);
      data_req = 1'b1; data_wr = w; data_size = s; data_addr = a; data_wdata = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (data_data_ok === 1'b1) begin got = 1; break; end
      end
      if (!got) begin
         compared++; errors++;
         $display("FAIL data_timeout: got no data_data_ok for %h, required a pulse", a);
      end
      @(negedge clk);
      data_req = 1'b0;
   endtask

   task automatic wait_accept(input int prev);
      for (int i = 0; i < 50 && acc_cnt == prev; i++) @(negedge clk);
      if (acc_cnt == prev) begin
         compared++; errors++;
         $display("FAIL accept_timeout: got no bus_addr_ok, required one");
      end
   endtask

   task automatic check_drained(input string name);
      compared++;
      if (exp_inst_q.size() != 0 || exp_data_q.size() != 0 || exp_bus_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drained: got inst=%0d data=%0d bus=%0d pending, required 0/0/0",
                  name, exp_inst_q.size(), exp_data_q.size(), exp_bus_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      compared++;
      if ({bus_req, bus_wr, bus_size, inst_data_ok, data_data_ok, stallreq_if, stallreq_mem} !== 8'b0 ||
          bus_addr !== 32'h0 || bus_wdata !== 32'h0 || inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b wr=%b size=%0d addr=%h wdata=%h iok=%b dok=%b irdata=%h drdata=%h, required all 0",
                  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, inst_data_ok, data_data_ok, inst_rdata, data_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if (bus_req !== 1'b0) begin
         errors++; $display("FAIL reset_idle: got bus_req=%b, required 0", bus_req);
      end
   endtask

   task automatic test_single_fetch();
      bit got;
      addr_lat = 0; data_lat = 2; got = 0;
      push_bus(32'hBFC0_0000, 1'b0, 2'd2, 32'h0);
      exp_inst_q.push_back(32'h3C08_0001);
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         compared++;
         if (inst_data_ok === 1'b1) begin
            if (stallreq_if !== 1'b0) begin
               errors++; $display("FAIL stall_if_at_ok: got %b, required 0", stallreq_if);
            end
            got = 1; break;
         end else if (stallreq_if !== 1'b1) begin
            errors++; $display("FAIL stall_if_wait: got %b, required 1", stallreq_if);
         end
      end
      if (!got) begin
         compared++; errors++; $display("FAIL single_fetch_timeout: got no pulse, required one");
      end
      @(negedge clk);
      inst_req = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (inst_rdata !== 32'h3C08_0001) begin
         errors++; $display("FAIL inst_rdata_hold: got %h, required 3c080001", inst_rdata);
      end
      check_drained("single_fetch");
   endtask

   task automatic test_contention();
      addr_lat = 1; data_lat = 1;
      push_bus(32'h8000_1000, 1'b0, 2'd2, 32'h0);
      push_bus(32'hBFC0_0100, 1'b0, 2'd2, 32'h0);
      exp_data_q.push_back(rsp_model(32'h8000_1000));
      exp_inst_q.push_back(rsp_model(32'hBFC0_0100));
      fork
         run_fetch(32'hBFC0_0100);
         run_data(1'b0, 2'd2, 32'h8000_1000, 32'h0);
      join
      repeat (3) @(negedge clk);
      compared++;
      if (!(dok_cyc < iok_cyc)) begin
         errors++; $display("FAIL contention_order: got data_ok cyc %0d inst_ok cyc %0d, required data first", dok_cyc, iok_cyc);
      end
      check_drained("contention");
   endtask

   task automatic test_store();
      addr_lat = 0; data_lat = 1;
      push_bus(32'h8000_0003, 1'b1, 2'd0, 32'h0000_00AA);
      exp_data_q.push_back(rsp_model(32'h8000_0003));
      run_data(1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AA);
      compared++;
      if (dok_cyc - bdok_cyc != 1) begin
         errors++; $display("FAIL store_latency: got %0d cycles after bus_data_ok, required 1", dok_cyc - bdok_cyc);
      end
      @(negedge clk);
      check_drained("store");
   endtask

   task automatic test_flush_data();
      int a0, fcyc;
      addr_lat = 0; data_lat = 3;
      push_bus(32'hBFC0_0200, 1'b0, 2'd2, 32'h0);
      a0 = acc_cnt;
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
      wait_accept(a0);
      @(negedge clk);
      compared++;
      if (bus_req !== 1'b0) begin
         errors++; $display("FAIL flush_in_data_state: got bus_req=%b, required 0", bus_req);
      end
      flush = 1'b1; inst_req = 1'b0; fcyc = cyc;
      @(negedge clk);
      flush = 1'b0;
      repeat (6) @(negedge clk);
      compared++;
      if (bdok_cyc <= fcyc) begin
         errors++; $display("FAIL flush_bus_complete: got last bus_data_ok cyc %0d, required after %0d", bdok_cyc, fcyc);
      end
      addr_lat = 1; data_lat = 1;
      push_bus(32'hBFC0_0380, 1'b0, 2'd2, 32'h0);
      exp_inst_q.push_back(rsp_model(32'hBFC0_0380));
      run_fetch(32'hBFC0_0380);
      @(negedge clk);
      check_drained("flush_data");
   endtask

   task automatic test_flush_idle();
      bit got;
      addr_lat = 1; data_lat = 0; got = 0;
      push_bus(32'hBFC0_0400, 1'b0, 2'd2, 32'h0);
      exp_inst_q.push_back(rsp_model(32'hBFC0_0400));
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'hBFC0_0400; flush = 1'b1;
      @(negedge clk);
      compared++;
      if (bus_req !== 1'b0) begin
         errors++; $display("FAIL flush_idle_nogrant: got bus_req=%b, required 0", bus_req);
      end
      flush = 1'b0;
      @(negedge clk);
      compared++;
      if (bus_req !== 1'b1) begin
         errors++; $display("FAIL flush_idle_grant: got bus_req=%b, required 1", bus_req);
      end
      for (int i = 0; i < 50; i++) begin
         if (inst_data_ok === 1'b1) begin got = 1; break; end
         @(negedge clk);
      end
      if (!got) begin
         compared++; errors++; $display("FAIL flush_idle_timeout: got no pulse, required one");
      end
      @(negedge clk);
      inst_req = 1'b0;
      @(negedge clk);
      check_drained("flush_idle");
   endtask

   task automatic test_reset_mid();
      int a0;
      addr_lat = 0; data_lat = 4;
      push_bus(32'hBFC0_0500, 1'b0, 2'd2, 32'h0);
      a0 = acc_cnt;
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'hBFC0_0500;
      wait_accept(a0);
      @(negedge clk);
      rst = 1'b1; inst_req = 1'b0;
      @(negedge clk);
      compared++;
      if (bus_req !== 1'b0 || inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: got bus_req=%b iok=%b dok=%b irdata=%h, required 0/0/0/0",
                  bus_req, inst_data_ok, data_data_ok, inst_rdata);
      end
      rst = 1'b0;
      repeat (8) @(negedge clk);
      compared++;
      if (bus_req !== 1'b0) begin
         errors++; $display("FAIL reset_mid_idle: got bus_req=%b, required 0", bus_req);
      end
      check_drained("reset_mid");
   endtask

   task automatic test_back_to_back();
      int c0;
      bit got;
      addr_lat = 0; data_lat = 0; got = 0;
      push_bus(32'hBFC0_0600, 1'b0, 2'd2, 32'h0);
      exp_inst_q.push_back(rsp_model(32'hBFC0_0600));
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'hBFC0_0600; c0 = cyc;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (inst_data_ok === 1'b1) begin got = 1; break; end
      end
      compared++;
      if (!got || cyc - c0 != 2) begin
         errors++; $display("FAIL min_latency: got %0d cycles (seen=%0d), required 2 after grant cycle", cyc - c0, got);
      end
      @(negedge clk);
      inst_req = 1'b0;
      push_bus(32'hBFC0_0604, 1'b0, 2'd2, 32'h0);
      exp_inst_q.push_back(rsp_model(32'hBFC0_0604));
      run_fetch(32'hBFC0_0604);
      push_bus(32'h8000_2000, 1'b1, 2'd1, 32'h1234_5678);
      exp_data_q.push_back(rsp_model(32'h8000_2000));
      run_data(1'b1, 2'd1, 32'h8000_2000, 32'h1234_5678);
      repeat (3) @(negedge clk);
      check_drained("back_to_back");
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
      test_reset();
      test_single_fetch();
      test_contention();
      test_store();
      test_flush_data();
      test_flush_idle();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1);
   end

endmodule
